// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stage-enable control for the 5-stage 16-bit core.
// Latency: enables/flush/bubble are combinational; fwd sels, store fwd, halted, counters are one edge later.
// Backpressure: mem_busy freezes every stage register and all internal state; branch > load-use > halt drain.
module pipe_hazard_ctrl #(
   parameter int REG_W     = 4,
   parameter int BR_STAGE  = 2,
   parameter int STORE_FWD = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_reg_wr,
   input  logic             id_is_load,
   input  logic             id_is_store,
   input  logic             id_is_hlt,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_store_fwd,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Destination info carried alongside each of the EX, MEM and WB stage registers.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_wr;
      logic             is_load;
      logic             is_hlt;
      logic             st_fwd;
   } shadow_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   shadow_t          ex_q, mem_q, wb_q, ex_d;
   logic             halt_q;
   logic             halted_q;
   logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic             lu_rs, lu_rt, st_exempt, load_use;
   logic             stall_evt, flush_evt;

   // Fields the WB/MEM shadows carry for completeness but nothing downstream reads.
   logic             unused_shadow_bits;
   assign unused_shadow_bits = ^{mem_q.is_load, wb_q.rd, wb_q.reg_wr, wb_q.is_load, wb_q.st_fwd};

   // A stage produces the value a source needs: live, writing, non-zero rd, same specifier.
   function automatic logic prod_match(input shadow_t s, input logic [REG_W-1:0] src, input logic used);
      return used && s.valid && s.reg_wr && (s.rd != '0) && (s.rd == src);
   endfunction

   // Load-use detection; a store whose only dependency is its data operand can take a late forward.
   always_comb begin
      lu_rs     = id_valid && ex_q.is_load && prod_match(ex_q, id_rs, id_rs_used);
      lu_rt     = id_valid && ex_q.is_load && prod_match(ex_q, id_rt, id_rt_used);
      st_exempt = (STORE_FWD != 0) && id_is_store && lu_rt && !lu_rs;
      load_use  = lu_rs || (lu_rt && !st_exempt);
   end

   // Operand selects for the instruction now in ID; the nearest older producer wins.
   always_comb begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (id_valid && prod_match(ex_q, id_rs, id_rs_used))       fwd_a_d = 2'b01;
      else if (id_valid && prod_match(mem_q, id_rs, id_rs_used)) fwd_a_d = 2'b10;
      if (id_valid && prod_match(ex_q, id_rt, id_rt_used))       fwd_b_d = 2'b01;
      else if (id_valid && prod_match(mem_q, id_rt, id_rt_used)) fwd_b_d = 2'b10;
   end

   // Stage-register enables and flush/bubble in priority order: freeze, branch, load-use, halt drain.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_evt    = 1'b0;
      flush_evt    = 1'b0;
      if (rst) begin
         // reset state already expressed by the defaults
      end else if (mem_busy) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (br_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = (BR_STAGE == 2);
         flush_evt    = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_evt    = 1'b1;
      end else if (halt_q) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Entry that ID/EX will receive: a NOP when bubbled, otherwise the decoded destination info.
   always_comb begin
      ex_d = '0;
      if (!id_ex_bubble) begin
         ex_d.valid   = id_valid;
         ex_d.rd      = id_rd;
         ex_d.reg_wr  = id_reg_wr;
         ex_d.is_load = id_is_load;
         ex_d.is_hlt  = id_is_hlt;
         ex_d.st_fwd  = st_exempt;
      end
   end

   // Shadow pipeline, registered forwarding selects and halt tracking; all hold while frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         fwd_a_q  <= 2'b00;
         fwd_b_q  <= 2'b00;
         halt_q   <= 1'b0;
         halted_q <= 1'b0;
      end else if (!mem_busy) begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         fwd_a_q <= id_ex_bubble ? 2'b00 : fwd_a_d;
         fwd_b_q <= id_ex_bubble ? 2'b00 : fwd_b_d;
         if (ex_d.valid && ex_d.is_hlt) halt_q <= 1'b1;
         if (wb_q.valid && wb_q.is_hlt) halted_q <= 1'b1;
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
         if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
   end

   assign fwd_a_sel     = fwd_a_q;
   assign fwd_b_sel     = fwd_b_q;
   assign mem_store_fwd = mem_q.valid && mem_q.st_fwd;
   assign halted        = halted_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random-stimulus bench for pipe_hazard_ctrl: two configurations driven in lockstep
// (EX-resolved branches with store forwarding, ID-resolved branches without) against an age-ordered reference.
module tb_pipe_hazard_ctrl;

   localparam int CW   = 4;
   localparam int NCYC = 6000;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       id_valid, id_rs_used, id_rt_used, id_reg_wr, id_is_load, id_is_store, id_is_hlt;
   logic [3:0] id_rs, id_rt, id_rd;
   logic       br_taken, mem_busy;

   logic          pc_write [2];
   logic          if_id_write [2];
   logic          id_ex_write [2];
   logic          ex_mem_write [2];
   logic          mem_wb_write [2];
   logic          if_id_flush [2];
   logic          id_ex_bubble [2];
   logic [1:0]    fwd_a_sel [2];
   logic [1:0]    fwd_b_sel [2];
   logic          mem_store_fwd [2];
   logic          halted [2];
   logic [CW-1:0] stall_cnt [2];
   logic [CW-1:0] flush_cnt [2];

   pipe_hazard_ctrl #(.REG_W(4), .BR_STAGE(2), .STORE_FWD(1), .CNT_W(CW)) u_dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_reg_wr(id_reg_wr),
      .id_is_load(id_is_load), .id_is_store(id_is_store), .id_is_hlt(id_is_hlt),
      .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_write(pc_write[0]), .if_id_write(if_id_write[0]), .id_ex_write(id_ex_write[0]),
      .ex_mem_write(ex_mem_write[0]), .mem_wb_write(mem_wb_write[0]),
      .if_id_flush(if_id_flush[0]), .id_ex_bubble(id_ex_bubble[0]),
      .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]), .mem_store_fwd(mem_store_fwd[0]),
      .halted(halted[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]));

   pipe_hazard_ctrl #(.REG_W(4), .BR_STAGE(1), .STORE_FWD(0), .CNT_W(CW)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_reg_wr(id_reg_wr),
      .id_is_load(id_is_load), .id_is_store(id_is_store), .id_is_hlt(id_is_hlt),
      .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_write(pc_write[1]), .if_id_write(if_id_write[1]), .id_ex_write(id_ex_write[1]),
      .ex_mem_write(ex_mem_write[1]), .mem_wb_write(mem_wb_write[1]),
      .if_id_flush(if_id_flush[1]), .id_ex_bubble(id_ex_bubble[1]),
      .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]), .mem_store_fwd(mem_store_fwd[1]),
      .halted(halted[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]));

   // Reference: per configuration, the three most recent entries to have entered EX, youngest first.
   typedef struct packed {
      bit       v;
      bit [3:0] rd;
      bit       wr;
      bit       ld;
      bit       hlt;
      bit       sf;
   } rec_t;

   int   brs_of [2] = '{2, 1};
   bit   sfe_of [2] = '{1'b1, 1'b0};
   rec_t flight [2][3];
   bit   hseen [2];
   bit   hltd [2];
   bit [1:0] fa [2];
   bit [1:0] fb [2];
   int   sc [2];
   int   fc [2];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit produces(input rec_t r, input logic [3:0] src, input logic used);
      return used && r.v && r.wr && (r.rd != 4'd0) && (r.rd == src);
   endfunction

   // Age (1 = just ahead, 2 = two ahead) of the nearest producer, or 0 if none forwards.
   function automatic bit [1:0] nearest(input int k, input logic [3:0] src, input logic used);
      for (int a = 0; a < 2; a++)
         if (id_valid && produces(flight[k][a], src, used)) return 2'(a + 1);
      return 2'd0;
   endfunction

   task automatic model_reset(input int k);
      for (int a = 0; a < 3; a++) flight[k][a] = '0;
      hseen[k] = 1'b0;
      hltd[k]  = 1'b0;
      fa[k]    = 2'd0;
      fb[k]    = 2'd0;
      sc[k]    = 0;
      fc[k]    = 0;
   endtask

   // Compare this cycle's outputs with the reference, then advance the reference past the next edge.
   task automatic model_cycle(input int k);
      rec_t     nr;
      bit       dep_rs, dep_rt, exempt, lu, bub;
      bit [6:0] ctl;
      dep_rs = id_valid && flight[k][0].ld && produces(flight[k][0], id_rs, id_rs_used);
      dep_rt = id_valid && flight[k][0].ld && produces(flight[k][0], id_rt, id_rt_used);
      exempt = sfe_of[k] && id_is_store && dep_rt && !dep_rs;
      lu     = dep_rs || (dep_rt && !exempt);
      // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
      if (mem_busy)               ctl = 7'b0000000;
      else if (br_taken)          ctl = {6'b111111, brs_of[k] == 2};
      else if (lu || hseen[k])    ctl = 7'b0011101;
      else                        ctl = 7'b1111100;

      check_val($sformatf("u%0d.ctl@%0d", k, cyc),
                {pc_write[k], if_id_write[k], id_ex_write[k], ex_mem_write[k], mem_wb_write[k],
                 if_id_flush[k], id_ex_bubble[k]}, ctl);
      check_val($sformatf("u%0d.fwd@%0d", k, cyc), {fwd_a_sel[k], fwd_b_sel[k]}, {fa[k], fb[k]});
      check_val($sformatf("u%0d.stfwd@%0d", k, cyc), mem_store_fwd[k], flight[k][1].v && flight[k][1].sf);
      check_val($sformatf("u%0d.halted@%0d", k, cyc), halted[k], hltd[k]);
      check_val($sformatf("u%0d.stall_cnt@%0d", k, cyc), stall_cnt[k], sc[k]);
      check_val($sformatf("u%0d.flush_cnt@%0d", k, cyc), flush_cnt[k], fc[k]);

      if (!mem_busy) begin
         bub = ctl[0];
         fa[k] = bub ? 2'd0 : nearest(k, id_rs, id_rs_used);
         fb[k] = bub ? 2'd0 : nearest(k, id_rt, id_rt_used);
         if (flight[k][2].v && flight[k][2].hlt) hltd[k] = 1'b1;
         nr = '0;
         if (!bub) begin
            nr.v   = id_valid;
            nr.rd  = id_rd;
            nr.wr  = id_reg_wr;
            nr.ld  = id_is_load;
            nr.hlt = id_is_hlt;
            nr.sf  = exempt;
         end
         flight[k][2] = flight[k][1];
         flight[k][1] = flight[k][0];
         flight[k][0] = nr;
         if (nr.v && nr.hlt) hseen[k] = 1'b1;
         if (br_taken) fc[k] = (fc[k] < CMAX) ? fc[k] + 1 : CMAX;
         else if (lu)  sc[k] = (sc[k] < CMAX) ? sc[k] + 1 : CMAX;
      end
   endtask

   initial begin
      int  halt_wait;
      bit  prev_busy, prev_br;
      rst = 1'b1;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_used = 0; id_rt_used = 0;
      id_reg_wr = 0; id_is_load = 0; id_is_store = 0; id_is_hlt = 0; br_taken = 0; mem_busy = 0;
      halt_wait = 0;
      prev_busy = 1'b0;
      prev_br   = 1'b0;
      model_reset(0);
      model_reset(1);

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc < 2) rst = 1'b1;
         else rst = (halt_wait >= 3) || ($urandom_range(0, 599) == 0);
         id_valid    = ($urandom_range(0, 7) != 0);
         id_rs       = 4'($urandom_range(0, 3));
         id_rt       = 4'($urandom_range(0, 3));
         id_rd       = 4'($urandom_range(0, 3));
         id_rs_used  = ($urandom_range(0, 3) != 0);
         id_rt_used  = ($urandom_range(0, 3) != 0);
         id_is_load  = ($urandom_range(0, 9) < 3);
         id_is_store = !id_is_load && ($urandom_range(0, 3) == 0);
         id_reg_wr   = id_is_load || (!id_is_store && ($urandom_range(0, 9) < 7));
         id_is_hlt   = !id_is_load && ($urandom_range(0, 299) == 0);
         // the datapath keeps a taken branch asserted through a freeze
         br_taken    = (prev_busy && prev_br) ? 1'b1 : ($urandom_range(0, 9) == 0);
         mem_busy    = prev_busy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
         prev_busy   = mem_busy;
         prev_br     = br_taken;

         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            else model_cycle(k);
         end
         if (!rst && hltd[0] && hltd[1]) halt_wait++;
         else halt_wait = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
